serial_addsub: RTL and testbench

- Multi-cycle, digit-serial adder/subtractor; successor to the 32-bit combinational subtractor.
- Width N and digit width DIGIT are parametrised; one runtime op select chooses add or subtract.
- Operands are accepted over a valid/ready handshake and processed DIGIT bits per clock, low digit first.
- Result and flags are returned over a second valid/ready handshake. Sits in front of the ALU result mux for area-constrained datapaths.

---
 rtl/serial_addsub.sv | 118 +++++++++++
 tb/tb_serial_addsub.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_addsub.sv
// Digit-serial N-bit adder/subtractor: DIGIT bits per clock, low digit first, valid/ready on both sides.
// Optional macro SERIAL_ADDSUB_SATURATE_EN clamps the result on signed overflow.
module serial_addsub #(
  parameter int N     = 32,
  parameter int DIGIT = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  input  logic         op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         c_out,
  output logic         overflow,
  output logic         zero
);

  localparam int NDIG = N / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  if ((N % DIGIT) != 0) begin : g_bad_digit
    $error("serial_addsub: N (%0d) must be a multiple of DIGIT (%0d)", N, DIGIT);
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   idx;
  logic            carry;
  logic [N-1:0]    a_sh, b_sh, acc;
  logic [DIGIT:0]  dsum;
  logic            accept, last;
  logic [N-1:0]    res_raw, res_fin;
  logic            ovf_fin;

`ifdef SERIAL_ADDSUB_SATURATE_EN
  function automatic logic [N-1:0] saturate(input logic [N-1:0] v, input logic ovf,
                                            input logic a_neg);
    if (!ovf) return v;
    return a_neg ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
  endfunction
`endif

  assign accept = in_valid && (state == IDLE);
  assign last   = (idx == CW'(NDIG - 1));
  assign dsum   = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + (DIGIT+1)'(carry);
  // New digit enters at the top; after the last digit the accumulator holds the full result.
  assign res_raw = N'({dsum[DIGIT-1:0], acc} >> DIGIT);
  // On the final digit a_sh/b_sh hold the operand MSBs in their top digit bit.
  assign ovf_fin = (a_sh[DIGIT-1] == b_sh[DIGIT-1]) && (dsum[DIGIT-1] != a_sh[DIGIT-1]);

`ifdef SERIAL_ADDSUB_SATURATE_EN
  assign res_fin = saturate(res_raw, ovf_fin, a_sh[DIGIT-1]);
`else
  assign res_fin = res_raw;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = BUSY;
      BUSY:    if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Operand shift registers and partial result: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_sh <= a;
      b_sh <= op ? ~b : b;
    end else if (state == BUSY) begin
      a_sh <= a_sh >> DIGIT;
      b_sh <= b_sh >> DIGIT;
      acc  <= res_raw;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx      <= '0;
      carry    <= 1'b0;
      sum      <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b0;
    end else if (accept) begin
      idx   <= '0;
      carry <= op ? ~c_in : c_in;
    end else if (state == BUSY) begin
      idx   <= idx + 1'b1;
      carry <= dsum[DIGIT];
      if (last) begin
        sum      <= res_fin;
        c_out    <= dsum[DIGIT];
        overflow <= ovf_fin;
        zero     <= (res_fin == '0);
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench for serial_addsub: one DIGIT=8 instance and one DIGIT=32 instance against
// an arithmetic reference model (honours SERIAL_ADDSUB_SATURATE_EN).
module tb_serial_addsub;

  logic        clk, rst_n;
  logic        in_valid_s [2];
  logic        in_ready_s [2];
  logic [31:0] a_s [2];
  logic [31:0] b_s [2];
  logic        c_in_s [2];
  logic        op_s [2];
  logic        out_valid_s [2];
  logic        out_ready_s [2];
  logic [31:0] sum_s [2];
  logic        c_out_s [2];
  logic        overflow_s [2];
  logic        zero_s [2];

  int tests = 0;
  int fails = 0;
  int ncyc  = 0;
  int ndig [2] = '{4, 1};

  logic        pend [2];
  int          exp_at [2];
  logic [34:0] exp_res [2];
  logic [34:0] held [2];

  serial_addsub #(.N(32), .DIGIT(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
    .a(a_s[0]), .b(b_s[0]), .c_in(c_in_s[0]), .op(op_s[0]),
    .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]), .sum(sum_s[0]),
    .c_out(c_out_s[0]), .overflow(overflow_s[0]), .zero(zero_s[0]));

  serial_addsub #(.N(32), .DIGIT(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
    .a(a_s[1]), .b(b_s[1]), .c_in(c_in_s[1]), .op(op_s[1]),
    .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]), .sum(sum_s[1]),
    .c_out(c_out_s[1]), .overflow(overflow_s[1]), .zero(zero_s[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: {sum, c_out, overflow, zero} from plain integer arithmetic.
  function automatic logic [34:0] model(input logic [31:0] av, input logic [31:0] bv,
                                        input logic ci, input logic o);
    longint      sr;
    logic [31:0] s;
    logic        c, ov;
    if (!o) begin
      sr = longint'($signed(av)) + longint'($signed(bv)) + (ci ? 1 : 0);
      s  = av + bv + 32'(ci);
      c  = ((64'(av) + 64'(bv) + 64'(ci)) > 64'hFFFF_FFFF);
    end else begin
      sr = longint'($signed(av)) - longint'($signed(bv)) - (ci ? 1 : 0);
      s  = av - bv - 32'(ci);
      c  = (64'(av) >= (64'(bv) + 64'(ci)));
    end
    ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
`ifdef SERIAL_ADDSUB_SATURATE_EN
    if (ov) s = (sr > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
    return {s, c, ov, (s == 32'h0)};
  endfunction

  always @(negedge clk) begin
    logic done;
    ncyc++;
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        pend[i] = 1'b0;
        held[i] = '0;
        check("rst_in_ready", in_ready_s[i], 1'b1);
        check("rst_out_valid", out_valid_s[i], 1'b0);
        check("rst_outputs", {sum_s[i], c_out_s[i], overflow_s[i], zero_s[i]}, 35'h0);
      end else begin
        if (pend[i] && ncyc == exp_at[i]) held[i] = exp_res[i];
        done = pend[i] && (ncyc >= exp_at[i]);
        check($sformatf("in_ready[%0d]", i), in_ready_s[i], !pend[i]);
        check($sformatf("out_valid[%0d]", i), out_valid_s[i], done);
        check($sformatf("result[%0d]", i),
              {sum_s[i], c_out_s[i], overflow_s[i], zero_s[i]}, held[i]);
        if (done && out_ready_s[i]) pend[i] = 1'b0;
        else if (!pend[i] && in_valid_s[i]) begin
          pend[i]    = 1'b1;
          exp_at[i]  = ncyc + 1 + ndig[i];
          exp_res[i] = model(a_s[i], b_s[i], c_in_s[i], op_s[i]);
        end
      end
    end
  end

  task automatic issue(input int i, input logic [31:0] av, input logic [31:0] bv,
                       input logic ci, input logic o, input bit early);
    bit ok = 0;
    @(posedge clk); #1;
    a_s[i] = av; b_s[i] = bv; c_in_s[i] = ci; op_s[i] = o;
    in_valid_s[i] = 1'b1; out_ready_s[i] = early;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk); ok = in_ready_s[i];
      @(posedge clk); #1;
    end
    in_valid_s[i] = 1'b0;
    a_s[i] = $urandom; b_s[i] = $urandom; op_s[i] = 1'($urandom_range(0, 1));
    check("accept", ok, 1'b1);
  endtask

  task automatic run_op(input int i, input logic [31:0] av, input logic [31:0] bv,
                        input logic ci, input logic o, input int hold, input bit early,
                        output logic [34:0] res);
    int lat = 0;
    res = '0;
    issue(i, av, bv, ci, o, early);
    do begin
      @(posedge clk); #1; lat++;
    end while (!out_valid_s[i] && lat < 50);
    check("out_valid_seen", out_valid_s[i], 1'b1);
    check("latency", lat, ndig[i]);
    res = {sum_s[i], c_out_s[i], overflow_s[i], zero_s[i]};
    if (!early) begin
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        a_s[i] = $urandom; b_s[i] = $urandom; c_in_s[i] = 1'($urandom_range(0, 1));
        check("hold_valid", out_valid_s[i], 1'b1);
        check("hold_in_ready", in_ready_s[i], 1'b0);
        check("hold_result", {sum_s[i], c_out_s[i], overflow_s[i], zero_s[i]}, res);
      end
      out_ready_s[i] = 1'b1;
    end
    @(posedge clk); #1;
    out_ready_s[i] = 1'b0;
    check("drain_valid", out_valid_s[i], 1'b0);
    check("drain_in_ready", in_ready_s[i], 1'b1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [34:0] r, sat_pos, sat_neg;
`ifdef SERIAL_ADDSUB_SATURATE_EN
    sat_pos = {32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};
    sat_neg = {32'h8000_0000, 1'b1, 1'b1, 1'b0};
`else
    sat_pos = {32'h8000_0000, 1'b0, 1'b1, 1'b0};
    sat_neg = {32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
`endif
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid_s[i] = 0; a_s[i] = 0; b_s[i] = 0; c_in_s[i] = 0; op_s[i] = 0;
      out_ready_s[i] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    check("model_sub_2_1", model(32'd2, 32'd1, 1'b0, 1'b1), {32'h1, 1'b1, 1'b0, 1'b0});
    check("model_sub_0_1", model(32'd0, 32'd1, 1'b0, 1'b1), {32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0});
    check("model_sub_5_5", model(32'd5, 32'd5, 1'b0, 1'b1), {32'h0, 1'b1, 1'b0, 1'b1});
    check("model_add_ovf", model(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0), sat_pos);
    check("model_sub_ovf", model(32'h8000_0000, 32'd1, 1'b0, 1'b1), sat_neg);

    for (int i = 0; i < 2; i++) begin
      run_op(i, 32'd2, 32'd1, 1'b0, 1'b1, 0, 1'b0, r);
      check("sub_2_1", r, {32'h1, 1'b1, 1'b0, 1'b0});
      run_op(i, 32'd0, 32'd1, 1'b0, 1'b1, 1, 1'b0, r);
      check("sub_0_1", r, {32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0});
      run_op(i, 32'd5, 32'd5, 1'b0, 1'b1, 0, 1'b1, r);
      check("sub_5_5", r, {32'h0, 1'b1, 1'b0, 1'b1});
      run_op(i, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 0, 1'b0, r);
      check("add_pos_ovf", r, sat_pos);
      run_op(i, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 0, 1'b0, r);
      check("add_wrap_zero", r, {32'h0, 1'b1, 1'b0, 1'b1});
    end

    run_op(0, 32'h1234_5678, 32'h0000_1111, 1'b0, 1'b0, 10, 1'b0, r);
    check("backpressure_sum", r, {32'h1234_6789, 1'b0, 1'b0, 1'b0});

    issue(0, 32'h0F0F_0F0F, 32'h0101_0101, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midbusy_rst_in_ready", in_ready_s[0], 1'b1);
    check("midbusy_rst_out_valid", out_valid_s[0], 1'b0);
    check("midbusy_rst_sum", sum_s[0], 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready_s[0] = 1'b0;
    repeat (8) @(posedge clk);
    #1 check("post_rst_no_valid", out_valid_s[0], 1'b0);

    for (int k = 0; k < 60; k++) begin
      run_op(k % 2, pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), r);
    end

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", fails);
    $fatal(1, "watchdog");
  end

endmodule
